// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: decodes one RV32 load/store, drives a
// single-outstanding req/ack data bus, formats store lanes and extends load data.
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [NB-1:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [NB-1:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [XLEN-1:0] rdata);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = rdata;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          off_r;
  logic [2:0]          f3_r;

  logic                accept_s;
  logic                dec_err_s;
  logic                timeout_s;

  logic                mem_req_nx_s;
  logic                mem_we_nx_s;
  logic [ADDR_W-1:0]   mem_addr_nx_s;
  logic [XLEN-1:0]     mem_wdata_nx_s;
  logic [NB-1:0]       mem_wstrb_nx_s;
  logic                resp_valid_nx_s;
  logic                resp_err_nx_s;
  logic [XLEN-1:0]     resp_rdata_nx_s;

  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign dec_err_s = !funct3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // State register plus the per-transaction context needed once the request is gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      off_r   <= 2'b00;
      f3_r    <= 3'b000;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= '0;
            off_r <= req_addr[1:0];
            f3_r  <= req_funct3;
          end
        end
        BUS: begin
          if (!mem_ack && !timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next-state logic; an ack in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = dec_err_s ? RESP : BUS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUS: begin
        if (mem_ack || timeout_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = BUS;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs.
  always_comb begin
    mem_req_nx_s    = 1'b0;
    mem_we_nx_s     = 1'b0;
    mem_addr_nx_s   = '0;
    mem_wdata_nx_s  = '0;
    mem_wstrb_nx_s  = '0;
    resp_valid_nx_s = 1'b0;
    resp_err_nx_s   = 1'b0;
    resp_rdata_nx_s = '0;
    case (state_r)
      IDLE: begin
        if (accept_s && dec_err_s) begin
          resp_valid_nx_s = 1'b1;
          resp_err_nx_s   = 1'b1;
        end else if (accept_s) begin
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = req_we;
          mem_addr_nx_s  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_nx_s = req_we ? store_data(req_funct3, req_wdata) : '0;
          mem_wstrb_nx_s = req_we ? store_strb(req_funct3, req_addr[1:0]) : '0;
        end else begin
          resp_valid_nx_s = 1'b0;
        end
      end
      BUS: begin
        if (mem_ack) begin
          resp_valid_nx_s = 1'b1;
          resp_rdata_nx_s = mem_we ? '0 : load_data(f3_r, off_r, mem_rdata);
        end else if (timeout_s) begin
          resp_valid_nx_s = 1'b1;
          resp_err_nx_s   = 1'b1;
        end else begin
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = mem_we;
          mem_addr_nx_s  = mem_addr;
          mem_wdata_nx_s = mem_wdata;
          mem_wstrb_nx_s = mem_wstrb;
        end
      end
      default: begin
        resp_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_req    <= mem_req_nx_s;
      mem_we     <= mem_we_nx_s;
      mem_addr   <= mem_addr_nx_s;
      mem_wdata  <= mem_wdata_nx_s;
      mem_wstrb  <= mem_wstrb_nx_s;
      resp_valid <= resp_valid_nx_s;
      resp_err   <= resp_err_nx_s;
      resp_rdata <= resp_rdata_nx_s;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan cases plus randomized
// transactions scored against an arithmetic reference model.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  int          o_lat, o_req;
  logic        o_err, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_wstrb;
  bit          o_stable, o_clean, o_after_ok;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Reference model: access size in bytes from funct3.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit m_dec_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit illegal;
    if (we) illegal = !(int'(f3) inside {0, 1, 2});
    else    illegal = !(int'(f3) inside {0, 1, 2, 4, 5});
    return illegal || ((addr % m_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    longint v;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return rdata;
    v = (longint'(rdata) >> (8 * (addr % 4))) & ((longint'(1) << (8 * sz)) - 1);
    if (f3 < 3'd4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return (wdata & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    s = ((1 << m_size(f3)) - 1) << (addr % 4);
    return s[3:0];
  endfunction

  // Drive one request and record what the DUT does; ack_at = mem_req cycle to ack (0 = never).
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    int n;
    o_lat = -1; o_req = 0; o_err = 1'b0; o_rdata = '0; o_we = 1'b0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0;
    o_stable = 1'b1; o_clean = 1'b1; o_after_ok = 1'b0;
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom()); req_funct3 = 3'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();
    for (n = 1; n <= 20; n++) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom();
      if (mem_req === 1'b1) begin
        o_req++;
        if (o_req == 1) begin
          o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
        end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
          o_stable = 1'b0;
        end
        if (o_req == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (resp_valid === 1'b1) begin
        o_lat = n; o_err = resp_err; o_rdata = resp_rdata;
        break;
      end else if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
        o_clean = 1'b0;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (o_lat > 0) begin
      @(negedge clk);
      o_after_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_valid, resp_err, resp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h strb=%b rv=%b err=%b rdata=%h, expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_valid, resp_err, resp_rdata);
    end
    n_assert++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_low: got %b expected 0", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_load_format();
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
    n_assert++;
    if (o_lat != 2 || o_err !== 1'b0 || o_rdata !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_resp: lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=ffffff80", o_lat, o_err, o_rdata);
    end
    n_assert++;
    if (o_req != 1 || o_addr !== 32'h0000_0100 || o_wstrb !== 4'b0000 || o_we !== 1'b0) begin
      n_fail++; $display("FAIL lb_bus: req=%0d addr=%h strb=%b we=%b expected 1 00000100 0000 0", o_req, o_addr, o_wstrb, o_we);
    end
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 1);
    n_assert++;
    if (o_err !== 1'b0 || o_rdata !== 32'h0000_9ABC || o_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL lhu: err=%b rdata=%h addr=%h expected 0 00009abc 00000200", o_err, o_rdata, o_addr);
    end
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 1);
    n_assert++;
    if (o_err !== 1'b0 || o_rdata !== 32'hFFFF_9ABC) begin
      n_fail++; $display("FAIL lh: err=%b rdata=%h expected 0 ffff9abc", o_err, o_rdata);
    end
    run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 3);
    n_assert++;
    if (o_lat != 4 || o_rdata !== 32'hCAFE_F00D || !o_stable || o_req != 3) begin
      n_fail++; $display("FAIL lw_ack3: lat=%0d rdata=%h stable=%b req=%0d expected 4 cafef00d 1 3", o_lat, o_rdata, o_stable, o_req);
    end
  endtask

  task automatic test_store_format();
    run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'hFFFF_FFFF, 1);
    n_assert++;
    if (o_wdata !== 32'hA5A5_A5A5 || o_wstrb !== 4'b0010 || o_we !== 1'b1 || o_addr !== 32'h0000_0300) begin
      n_fail++; $display("FAIL sb_bus: wdata=%h strb=%b we=%b addr=%h expected a5a5a5a5 0010 1 00000300", o_wdata, o_wstrb, o_we, o_addr);
    end
    n_assert++;
    if (o_lat != 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL sb_resp: lat=%0d err=%b rdata=%h expected 2 0 0", o_lat, o_err, o_rdata);
    end
    run_txn(1'b1, 3'b001, 32'h0000_0302, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2);
    n_assert++;
    if (o_wdata !== 32'hBEEF_BEEF || o_wstrb !== 4'b1100 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL sh: wdata=%h strb=%b rdata=%h err=%b expected beefbeef 1100 0 0", o_wdata, o_wstrb, o_rdata, o_err);
    end
  endtask

  task automatic test_decode_err();
    logic [2:0]  f3s  [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] adrs [4] = '{32'h401, 32'h400, 32'h400, 32'h303};
    bit          wes  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_txn(wes[i], f3s[i], adrs[i], 32'h5555_AAAA, 32'h1111_2222, 1);
      n_assert++;
      if (o_lat != 1 || o_err !== 1'b1 || o_req != 0 || o_rdata !== 32'h0 || !o_after_ok) begin
        n_fail++; $display("FAIL dec_err[%0d]: lat=%0d err=%b req=%0d rdata=%h after=%b expected 1 1 0 0 1",
                           i, o_lat, o_err, o_req, o_rdata, o_after_ok);
      end
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h7777_7777, 0);
    n_assert++;
    if (o_req != TO || o_lat != TO + 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout: req=%0d lat=%0d err=%b rdata=%h expected %0d %0d 1 0", o_req, o_lat, o_err, o_rdata, TO, TO + 1);
    end
    run_txn(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h7777_7777, TO);
    n_assert++;
    if (o_req != TO || o_lat != TO + 1 || o_err !== 1'b0 || o_rdata !== 32'h7777_7777) begin
      n_fail++; $display("FAIL ack_wins: req=%0d lat=%0d err=%b rdata=%h expected %0d %0d 0 77777777", o_req, o_lat, o_err, o_rdata, TO, TO + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_req_on: got %b expected 1", mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drop: req=%b rv=%b ready=%b expected 0 0 0", mem_req, resp_valid, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ready: ready=%b rv=%b expected 1 0", req_ready, resp_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
    end
    n_assert++;
    if (!quiet) begin
      n_fail++; $display("FAIL late_ack: saw resp_valid or mem_req, expected both 0");
    end
    run_txn(1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 2);
    n_assert++;
    if (o_lat != 3 || o_err !== 1'b0 || o_rdata !== 32'h0BAD_CAFE) begin
      n_fail++; $display("FAIL after_rst_lw: lat=%0d err=%b rdata=%h expected 3 0 0badcafe", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_random();
    int          lds [5] = '{0, 1, 2, 4, 5};
    bit          we, dec;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata, e_rdata;
    int          ack_at, e_lat, e_req;
    logic        e_err;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'(lds[$urandom_range(0, 4)]);
      addr = $urandom(); wdata = $urandom(); rdata = $urandom();
      ack_at = $urandom_range(0, TO);
      run_txn(we, f3, addr, wdata, rdata, ack_at);
      dec = m_dec_err(we, f3, addr);
      if (dec) begin
        e_lat = 1; e_err = 1'b1; e_req = 0; e_rdata = '0;
      end else if (ack_at >= 1) begin
        e_lat = ack_at + 1; e_err = 1'b0; e_req = ack_at; e_rdata = we ? 32'h0 : m_load(f3, addr, rdata);
      end else begin
        e_lat = TO + 1; e_err = 1'b1; e_req = TO; e_rdata = '0;
      end
      n_assert++;
      if (o_lat != e_lat || o_err !== e_err || o_rdata !== e_rdata || o_req != e_req) begin
        n_fail++; $display("FAIL rand_resp[%0d] we=%b f3=%b addr=%h: lat=%0d err=%b rdata=%h req=%0d expected %0d %b %h %0d",
                           i, we, f3, addr, o_lat, o_err, o_rdata, o_req, e_lat, e_err, e_rdata, e_req);
      end
      n_assert++;
      if (!o_stable || !o_clean || !o_after_ok) begin
        n_fail++; $display("FAIL rand_proto[%0d]: stable=%b clean=%b after=%b expected 1 1 1", i, o_stable, o_clean, o_after_ok);
      end
      if (!dec) begin
        n_assert++;
        if (o_addr !== (addr & 32'hFFFF_FFFC) || o_we !== we || o_wstrb !== (we ? m_wstrb(f3, addr) : 4'b0000)
            || (we && o_wdata !== m_wdata(f3, wdata))) begin
          n_fail++; $display("FAIL rand_bus[%0d] f3=%b addr=%h: maddr=%h we=%b strb=%b wdata=%h expected %h %b %b %h",
                             i, f3, addr, o_addr, o_we, o_wstrb, o_wdata, addr & 32'hFFFF_FFFC, we,
                             we ? m_wstrb(f3, addr) : 4'b0000, m_wdata(f3, wdata));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          idx [$];
    int          bad_data, bad_gap;
    logic [31:0] d;
    d = $urandom();
    bad_data = 0; bad_gap = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h800;
    for (int n = 0; n < 30; n++) begin
      mem_ack = mem_req; mem_rdata = d;
      if (resp_valid === 1'b1) begin
        idx.push_back(n);
        if (resp_rdata !== d || resp_err !== 1'b0) bad_data++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      mem_ack = mem_req;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    for (int k = 1; k < idx.size(); k++) if (idx[k] - idx[k-1] != 3) bad_gap++;
    n_assert++;
    if (idx.size() < 9 || bad_gap != 0 || bad_data != 0) begin
      n_fail++; $display("FAIL back_to_back: responses=%0d bad_gaps=%0d bad_data=%0d expected >=9 0 0", idx.size(), bad_gap, bad_data);
    end
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_store_format();
    test_decode_err();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencing controller for the RV32IM core's data-memory port. Accepts one load or store request from the execute/memory stage and drives a single-outstanding request/acknowledge memory bus. It generates byte strobes and lane-replicated store data, and aligns and sign/zero-extends load data. Misaligned accesses, illegal funct3 encodings and bus timeouts are reported to the pipeline as errors.

Parameters:
XLEN, 32, data width; fixed at 32 for RV32, byte lanes = XLEN/8.
ADDR_W, 32, address width.
TIMEOUT, 255, maximum cycles mem_req is held without mem_ack before an error response; must be >=1.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  pipeline request valid.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_err  out  1  error flag, valid with resp_valid.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
mem_req  out  1  bus request, held until ack or timeout.
mem_we  out  1  bus write enable.
mem_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}).
mem_wdata  out  XLEN  lane-replicated store data.
mem_wstrb  out  XLEN/8  byte strobes; 0 for loads.
mem_ack  in  1  bus completion, single cycle.
mem_rdata  in  XLEN  read data, valid when mem_ack=1.

Behaviour:
- Reset: all registered outputs 0; req_ready = 0 while rst=1; state = IDLE; timeout counter = 0. rst mid-transaction: mem_req drops at the next edge, the transaction is discarded, and no resp_valid is produced. A mem_ack arriving after reset is ignored.
- FSM states: IDLE, BUS, RESP.
- req_ready = (state==IDLE) && !rst. A request is accepted on an edge where req_valid && req_ready.
- IDLE, on accept:
  - Legal encodings: loads 000/001/010/100/101; stores 000/001/010. Any other funct3 is illegal.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - If illegal or misaligned, go to RESP with err=1 and never assert mem_req.
  - Otherwise latch mem_addr/mem_we/mem_wdata/mem_wstrb, the lane offset addr[1:0] and funct3; set mem_req=1, counter=0, and go to BUS.
- BUS:
  - mem_req and all mem_* outputs are held stable.
  - mem_ack=1: for loads, capture the extracted data; go to RESP with err=0 and drop mem_req.
  - Otherwise counter++. When counter reaches TIMEOUT-1 without ack, go to RESP with err=1 and drop mem_req.
  - If ack and timeout expiry occur in the same cycle, ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err are valid only while resp_valid=1 and are 0 otherwise.
- Store formatting:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001<<addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata unchanged, wstrb = 4'b1111.
- Load formatting:
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Latency:
  - Accept edge T0, mem_req high from T0+1. Ack sampled at edge Tk gives resp_valid during cycle Tk+1.
  - Minimum load/store latency is 2 cycles (ack in the first mem_req cycle).
  - Error on decode: resp_valid in the cycle after accept.
- Single outstanding transaction; no new request is accepted until RESP returns to IDLE. Back-to-back throughput is 1 request per 3 cycles minimum.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234, ack on first cycle -> mem_addr=0x100, mem_wstrb=0, resp_rdata=0xFFFF_FF80, resp_err=0, resp_valid 2 cycles after accept.
- LHU at 0x202, mem_rdata=0x9ABC_0000 -> resp_rdata=0x0000_9ABC; same with LH -> 0xFFFF_9ABC.
- SB at 0x301, wdata=0x1234_56A5 -> mem_wdata=0xA5A5_A5A5, mem_wstrb=4'b0010, mem_we=1. SH at 0x302, wdata=0xDEAD_BEEF -> mem_wdata=0xBEEF_BEEF, wstrb=4'b1100. resp_rdata=0 in both cases.
- LW at 0x401 and funct3=3'b011 -> resp_err=1 one cycle after accept, mem_req never asserted.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then resp_valid with resp_err=1. Repeat with ack on the 4th cycle -> resp_err=0 (ack wins).
- rst asserted on the 2nd mem_req cycle -> mem_req=0 the next cycle, no resp_valid, req_ready=1 one cycle after rst deasserts. A late mem_ack is ignored, and the next LW completes normally.
